fifo_wr_arbiter: RTL

Round-robin write arbiter sharing one `synchronous_fifo` write port among NUM_REQ producers. Each producer offers words on a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst and drives the FIFO's `w_en`/`data_in`. Each word is tagged with its source ID so the consumer side can demultiplex.

---
 rtl/fifo_arb_pkg.sv | 19 +
 rtl/rr_pick.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
//   Shared definitions for the FIFO write-port arbiter and the consumer-side
//   schedulers that reuse its round-robin picker.
//   Contents:
//     arb_state_e : arbiter FSM states (IDLE, BURST)
//     id_width()  : width of a requester tag for a given requester count
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  // Tag width for n requesters; never below one bit so a tag field always exists.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
//   Combinational N-way round-robin selector. The search starts at last+1 and
//   wraps modulo N, so the index named by 'last' has the lowest priority.
//   Ports:
//     req   in  N   request vector
//     last  in  IW  index that most recently finished service
//     found out 1   at least one request is set
//     idx   out IW  winning index (0 when nothing is found)
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Scan offsets from farthest to nearest so the nearest requester after 'last' wins.
  always_comb begin
    found = 1'b0;
    idx   = {IW{1'b0}};
    for (int i = N; i >= 1; i--) begin
      if (req[(int'(last) + i) % N]) begin
        found = 1'b1;
        idx   = IW'((int'(last) + i) % N);
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter sharing one synchronous FIFO write port among NUM_REQ
//   valid/ready producers. A winner keeps the port for up to MAX_BURST words;
//   each written word carries its source id in the upper bits.
//   Ports:
//     clk, rst_n   clock, synchronous active-low reset
//     req_valid    per-requester word available
//     req_data     packed payloads, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//     req_ready    one-hot-or-zero accept strobe
//     fifo_full    FIFO full flag
//     fifo_w_en    FIFO write enable
//     fifo_data    {source id, payload}
//     grant_id     current owner (BURST) or arbitration winner (IDLE)
//     busy         arbiter is in a burst
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = 4,
  localparam int IDW        = id_width(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_w_en,
  output logic [IDW+DATA_WIDTH-1:0]   fifo_data,
  output logic [IDW-1:0]              grant_id,
  output logic                        busy
);

  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_e     state_r, state_nxt_s;
  logic [IDW-1:0] owner_r, owner_nxt_s;
  logic [IDW-1:0] last_r, last_nxt_s;
  logic [CW-1:0]  count_r, count_nxt_s;

  logic           pick_found_s;
  logic [IDW-1:0] pick_idx_s;
  logic           xfer_s;
  logic [IDW-1:0] gnt_s;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IDW)
  ) u_pick (
    .req   (req_valid),
    .last  (last_r),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  // State, owner, priority pointer and burst counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      owner_r <= {IDW{1'b0}};
      last_r  <= IDW'(NUM_REQ - 1);
      count_r <= {CW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      owner_r <= owner_nxt_s;
      last_r  <= last_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  // Next-state logic; also decides whether a word moves this cycle and for whom.
  always_comb begin
    state_nxt_s = state_r;
    owner_nxt_s = owner_r;
    last_nxt_s  = last_r;
    count_nxt_s = count_r;
    xfer_s      = 1'b0;
    gnt_s       = {IDW{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (pick_found_s) begin
          gnt_s = pick_idx_s;
          if (!fifo_full) begin
            xfer_s      = 1'b1;
            count_nxt_s = CW'(1);
            owner_nxt_s = pick_idx_s;
            if (MAX_BURST == 1) begin
              // Single-word bursts never enter BURST; rotate priority right away.
              last_nxt_s = pick_idx_s;
            end else begin
              state_nxt_s = ST_BURST;
            end
          end else begin
            xfer_s = 1'b0;
          end
        end else begin
          gnt_s = {IDW{1'b0}};
        end
      end
      ST_BURST: begin
        gnt_s = owner_r;
        if (!req_valid[owner_r]) begin
          // Owner went quiet (even while stalled on full): give up the port.
          last_nxt_s  = owner_r;
          state_nxt_s = ST_IDLE;
        end else if (!fifo_full) begin
          xfer_s      = 1'b1;
          count_nxt_s = count_r + CW'(1);
          if ((count_r + CW'(1)) == CW'(MAX_BURST)) begin
            last_nxt_s  = owner_r;
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_BURST;
          end
        end else begin
          // Stalled on full: freeze count and ownership.
          xfer_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output datapath; everything is forced low while reset is asserted.
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    fifo_w_en = 1'b0;
    fifo_data = {(IDW + DATA_WIDTH){1'b0}};
    grant_id  = {IDW{1'b0}};
    busy      = 1'b0;
    if (rst_n) begin
      grant_id = gnt_s;
      busy     = (state_r == ST_BURST);
      if (xfer_s) begin
        req_ready[gnt_s] = 1'b1;
        fifo_w_en        = 1'b1;
        fifo_data        = {gnt_s, req_data[gnt_s*DATA_WIDTH +: DATA_WIDTH]};
      end else begin
        fifo_w_en = 1'b0;
      end
    end else begin
      busy = 1'b0;
    end
  end

endmodule
